registro_carga_hs: RTL and testbench
====================================

Name: registro_carga_hs

Overview:
Parametrised output capture stage for the ALU/display datapath. Latches N-bit arithmetic results and SEGS seven-segment patterns into an output register, using a valid/ready handshake. A 2-entry skid buffer means no result is lost while the downstream display/consumer stalls or a freeze is requested. It also keeps a count of accepted results.

Parameters:
N, 4, width of the arithmetic result channel
SEGS, 3, number of seven-segment channels, 7 bits each, packed channel 0 in bits [6:0]
CNT_W, 8, width of the accepted-results counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept a result this cycle
seg_in  input  7*SEGS  packed segment patterns from the decoders
aritm_in  input  N  arithmetic result from the ALU
out_valid  output  1  seg_out/aritm_out hold an undelivered result
out_ready  input  1  downstream consumes result this cycle
hold  input  1  freeze request: output contents do not advance while 1
seg_out  output  7*SEGS  registered segment patterns
aritm_out  output  N  registered arithmetic result
load_count  output  CNT_W  number of accepted inputs, modulo 2^CNT_W

Behaviour:
- Reset (rst==0 at a clk edge):
  - state EMPTY, out_valid=0
  - seg_out all ones (segments off, active-low displays)
  - aritm_out=0, skid register cleared, load_count=0
  - Reset mid-transfer discards both entries.
- in_ready is combinational and equals (rst==1 && state!=FULL). It is 0 while reset is asserted.
- accept = in_valid && in_ready; drain = out_valid && out_ready && !hold.
- State EMPTY (out_valid=0):
  - accept: main<=inputs; go to ONE. out_valid=1 the next cycle (latency 1 cycle).
- State ONE (main valid, skid empty):
  - accept && drain: main<=inputs, stay ONE. This gives full throughput, 1 result per cycle.
  - accept && !drain: skid<=inputs, go to FULL.
  - !accept && drain: go to EMPTY, out_valid=0 the next cycle.
  - Otherwise hold.
- State FULL (main and skid valid, in_ready=0):
  - drain: main<=skid, go to ONE.
  - Otherwise hold.
- Ordering: strict FIFO. The skid entry is always presented after the current main entry.
- hold=1 masks drain only. Inputs are still accepted into free entries, so at most 2 results are buffered during a freeze.
- Data outputs change only on a main-register load. Otherwise they are stable, including when out_valid=0 (last value retained, unless the optional feature is enabled).
- load_count increments by 1 on every accept and wraps from 2^CNT_W-1 to 0. It does not count drops (there are none) or drains.
- in_valid while in_ready=0: input ignored, no state change. Upstream must keep data stable until accepted.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro REGCARGA_BLANK_EN.
- Defined: seg_out is forced to all ones whenever out_valid=0. aritm_out is unaffected.
  - The forcing is a registered effect: seg_out goes all ones the cycle after the entry drains.
  - The stored value is restored on the next load.
- Undefined: seg_out always shows the main register contents, including after the entry drains.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then 1 -> seg_out=all ones, aritm_out=0, out_valid=0, in_ready=1, load_count=0.
2. Single transfer, N=4: in_valid=1 for 1 cycle, aritm_in=4'hA, seg_in channel0=7'h08, out_ready=1 -> next cycle out_valid=1, aritm_out=4'hA; following cycle out_valid=0; load_count=1.
3. Back-to-back streaming: 5 results 1..5, one per cycle, out_ready=1 -> in_ready stays 1; outputs 1..5 on consecutive cycles; load_count=5.
4. Stall/skid: out_ready=0, inputs 7 then 9 -> after the second accept in_ready=0 (FULL). A third input 3 held valid is not taken. Raise out_ready -> outputs 7, 9, 3 in order; load_count=3.
5. Freeze: hold=1 with out_ready=1 and inputs 2, 6 -> aritm_out stays 2, in_ready=0 after 6. Drop hold -> 6 presented next, then drains.
6. Reset mid-operation in FULL, and wrap: rst=0 for 1 cycle with 2 entries buffered -> out_valid=0, load_count=0, FULL cleared. With CNT_W=8 and 256 accepts -> load_count returns to 0.

Source files
------------

// File: rtl/registro_carga_hs.sv
// registro_carga_hs: output capture stage for the ALU/display datapath.
// Buffers arithmetic results and seven-segment patterns behind a valid/ready
// handshake. The main register feeds the outputs. A one-entry skid register
// sits behind it, so no result is lost while the consumer stalls or a freeze
// (hold) is requested. Every accepted result is counted modulo 2^CNT_W.
//
// Optional feature, macro REGCARGA_BLANK_EN: when it is defined, seg_out reads
// all ones (blank display) while no result is valid.
module registro_carga_hs #(
  parameter int N     = 4,
  parameter int SEGS  = 3,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7*SEGS-1:0] seg_in,
  input  logic [N-1:0]      aritm_in,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              hold,
  output logic [7*SEGS-1:0] seg_out,
  output logic [N-1:0]      aritm_out,
  output logic [CNT_W-1:0]  load_count
);

  localparam int SW = 7*SEGS;
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  // One buffered result: segment patterns plus arithmetic value.
  typedef struct packed {
    logic [SW-1:0] seg;
    logic [N-1:0]  aritm;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nx;
  entry_t main_q, skid_q, in_e, load_val;
  logic   accept, drain, load_main, load_skid;

  assign in_e.seg   = seg_in;
  assign in_e.aritm = aritm_in;

  // While reset is held the stage never claims to be ready.
  assign in_ready = rst && (state != FULL);
  assign accept   = in_valid && in_ready;
  // hold masks only the consumer side; the producer side keeps filling slots.
  assign drain    = out_valid && out_ready && !hold;

  // Next-state and load selection. The main register takes the input directly
  // when it is free or is being vacated with the skid empty. When the skid
  // holds data, the skid entry moves forward instead, which keeps FIFO order.
  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    load_val  = in_e;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_nx  = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nx  = FULL;
        end else if (drain) begin
          state_nx  = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          load_main = 1'b1;
          load_val  = skid_q;
          state_nx  = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // State, storage and counter. The reset is synchronous, and a reset during
  // a transfer discards both buffered entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= EMPTY;
      out_valid    <= 1'b0;
      main_q.seg   <= '1;
      main_q.aritm <= '0;
      skid_q       <= '0;
      load_count   <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx != EMPTY);
      if (load_main) main_q     <= load_val;
      if (load_skid) skid_q     <= in_e;
      if (accept)    load_count <= load_count + CNT_INC;
    end
  end

  assign aritm_out = main_q.aritm;

`ifdef REGCARGA_BLANK_EN
  // Blank the display whenever nothing valid is held. out_valid is a register,
  // so the blanking appears the cycle after the last entry drains. The stored
  // pattern is untouched and shows again after the next load.
  assign seg_out = out_valid ? main_q.seg : '1;
`else
  // The last loaded pattern stays on the display even after it drains.
  assign seg_out = main_q.seg;
`endif

endmodule

// File: tb/tb_registro_carga_hs.sv
// Bench for registro_carga_hs. The reference model is a FIFO queue of at most
// two results plus a modulo counter, stepped from the handshake rules. Directed
// sequences come first, then constrained-random traffic with occasional resets.
module tb_registro_carga_hs;

  localparam int N = 4, SEGS = 3, CNT_W = 8, SW = 7*SEGS;
  localparam logic [SW-1:0] SEG_OFF = '1;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, out_valid, out_ready, hold;
  logic [SW-1:0]     seg_in, seg_out;
  logic [N-1:0]      aritm_in, aritm_out;
  logic [CNT_W-1:0]  load_count;

  always #5 clk = ~clk;

  registro_carga_hs #(.N(N), .SEGS(SEGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .seg_in(seg_in), .aritm_in(aritm_in), .out_valid(out_valid),
    .out_ready(out_ready), .hold(hold), .seg_out(seg_out),
    .aritm_out(aritm_out), .load_count(load_count)
  );

  typedef struct {
    logic [SW-1:0] seg;
    logic [N-1:0]  ar;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   cnt;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the outputs against the model, then
  // let the edge happen and advance the model.
  task automatic cyc(input logic v, input logic [N-1:0] a, input logic [SW-1:0] s,
                     input logic ordy, input logic hld, input logic r, output logic acc);
    logic [SW-1:0] exp_seg;
    logic drn;
    in_valid = v; aritm_in = a; seg_in = s; out_ready = ordy; hold = hld; rst = r;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, (r && q.size() < 2)});
    chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
    chk("aritm_out", 32'(aritm_out), 32'(last.ar));
`ifdef REGCARGA_BLANK_EN
    exp_seg = (q.size() > 0) ? last.seg : SEG_OFF;
`else
    exp_seg = last.seg;
`endif
    chk("seg_out", 32'(seg_out), 32'(exp_seg));
    chk("load_count", 32'(load_count), 32'(cnt));
    acc = v && r && (q.size() < 2);
    drn = (q.size() > 0) && ordy && !hld;
    @(posedge clk);
    if (!r) begin
      q.delete();
      cnt  = 0;
      last = '{seg: SEG_OFF, ar: '0};
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back('{seg: s, ar: a});
        cnt = (cnt + 1) % (1 << CNT_W);
      end
      if (q.size() > 0) last = q[0];
    end
    @(negedge clk);
  endtask

  function automatic logic [SW-1:0] segs(input logic [6:0] ch0);
    return {{(SW-7){1'b1}}, ch0};
  endfunction

  initial begin
    logic acc;
    logic pv;
    logic [N-1:0] pa;
    logic [SW-1:0] ps;

    in_valid = 0; aritm_in = '0; seg_in = '0; out_ready = 0; hold = 0; rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cnt = 0; last = '{seg: SEG_OFF, ar: '0};

    // Reset, then idle.
    cyc(0, 0, 0, 0, 0, 1, acc);
    // A single transfer.
    cyc(1, 4'hA, segs(7'h08), 1, 0, 1, acc);
    cyc(0, 0, 0, 1, 0, 1, acc);
    cyc(0, 0, 0, 1, 0, 1, acc);
    // Back-to-back streaming of 1..5.
    for (int i = 1; i <= 5; i++) cyc(1, N'(i), segs(7'(i)), 1, 0, 1, acc);
    cyc(0, 0, 0, 1, 0, 1, acc);
    cyc(0, 0, 0, 1, 0, 1, acc);
    // Stall with the skid filling up; a third result waits until there is room.
    cyc(1, 4'd7, segs(7'h07), 0, 0, 1, acc);
    cyc(1, 4'd9, segs(7'h09), 0, 0, 1, acc);
    cyc(1, 4'd3, segs(7'h03), 0, 0, 1, acc);
    cyc(1, 4'd3, segs(7'h03), 0, 0, 1, acc);
    cyc(1, 4'd3, segs(7'h03), 1, 0, 1, acc);
    cyc(1, 4'd3, segs(7'h03), 1, 0, 1, acc);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 1, acc);
    // Freeze while the consumer is ready.
    cyc(1, 4'd2, segs(7'h02), 1, 1, 1, acc);
    cyc(1, 4'd6, segs(7'h06), 1, 1, 1, acc);
    for (int i = 0; i < 3; i++) cyc(1, 4'd5, segs(7'h05), 1, 1, 1, acc);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 1, acc);
    // Reset while FULL.
    cyc(1, 4'd1, segs(7'h11), 0, 0, 1, acc);
    cyc(1, 4'd4, segs(7'h14), 0, 0, 1, acc);
    cyc(0, 0, 0, 0, 0, 0, acc);
    cyc(0, 0, 0, 1, 0, 1, acc);
    // Counter wrap after 256 accepts.
    for (int i = 0; i < 256; i++) cyc(1, N'(i), SW'($urandom), 1, 0, 1, acc);
    chk("wrap", 32'(load_count), 32'd0);
    cyc(0, 0, 0, 1, 0, 1, acc);

    // Random traffic; a pending input stays stable until it is accepted.
    pv = 0; pa = '0; ps = '0;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pa = N'($urandom);
        ps = SW'($urandom);
      end
      r = ($urandom_range(0, 149) != 0);
      cyc(pv, pa, ps, ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0), r, acc);
      if (acc || !r) pv = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
